// File: rtl/usb_device_protocol.sv
// USB device-side transaction responder for one IN and one OUT bulk endpoint.
// Defining USB_DEV_TOGGLE_EN enables DATA0/DATA1 sequence tracking.
module usb_device_protocol #(
  parameter logic [6:0] DEV_ADDR    = 7'd5,
  parameter logic [3:0] ENDP_IN     = 4'd8,
  parameter logic [3:0] ENDP_OUT    = 4'd4,
  parameter logic [7:0] TIMEOUT_LEN = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [98:0] pkt_from_dec,
  input  logic        pkt_from_dec_avail,
  input  logic        pkt_from_dec_corrupt,
  output logic [98:0] pkt_to_enc,
  output logic        pkt_to_enc_avail,
  input  logic        pkt_sent,
  input  logic [63:0] data_in,
  input  logic        data_in_valid,
  output logic        data_in_ready,
  output logic [63:0] data_out,
  output logic        data_out_valid,
  input  logic        sink_ready,
  output logic        xact_done,
  output logic        xact_ok
);

  localparam logic [7:0] SYNC      = 8'h01;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;

  typedef enum logic [2:0] {S_IDLE, S_RX_DATA, S_TX_HS, S_TX_DATA, S_WAIT_HS} state_t;

  function automatic logic [98:0] hs_pkt(input logic [7:0] pid);
    return {SYNC, pid, 83'b0};
  endfunction

  function automatic logic [98:0] data_pkt(input logic [7:0] pid, input logic [63:0] payload);
    return {SYNC, pid, payload, 19'b0};
  endfunction

  state_t      state, state_nxt;
  logic [7:0]  timer;
  logic [98:0] pkt_hold;

  logic [7:0]  rx_pid;
  logic        clean, tok_out, tok_in, is_data, timeout;
  logic        seq_ok;
  logic [7:0]  tx_pid;

  logic        ld_pkt, deliver, done_ev, ok_ev, ack_in;
  logic [98:0] ld_val;

  logic unused_pkt_bits;
  assign unused_pkt_bits = ^{pkt_from_dec[98:91], pkt_from_dec[18:0]};

  assign rx_pid  = pkt_from_dec[90:83];
  assign clean   = pkt_from_dec_avail & ~pkt_from_dec_corrupt;
  assign tok_out = clean && rx_pid == PID_OUT && pkt_from_dec[82:76] == DEV_ADDR
                   && pkt_from_dec[75:72] == ENDP_OUT;
  assign tok_in  = clean && rx_pid == PID_IN && pkt_from_dec[82:76] == DEV_ADDR
                   && pkt_from_dec[75:72] == ENDP_IN;
  assign is_data = rx_pid == PID_DATA0 || rx_pid == PID_DATA1;
  assign timeout = timer == TIMEOUT_LEN;

`ifdef USB_DEV_TOGGLE_EN
  logic rx_tog, tx_tog;
  // A DATA PID that disagrees with rx_tog is a host retry of an already-delivered packet.
  assign seq_ok = rx_pid == (rx_tog ? PID_DATA1 : PID_DATA0);
  assign tx_pid = tx_tog ? PID_DATA1 : PID_DATA0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_tog <= 1'b0;
      tx_tog <= 1'b0;
    end else begin
      if (deliver) rx_tog <= ~rx_tog;
      if (ack_in)  tx_tog <= ~tx_tog;
    end
  end
`else
  assign seq_ok = 1'b1;
  assign tx_pid = PID_DATA0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (tok_out)     state_nxt = S_RX_DATA;
        else if (tok_in) state_nxt = data_in_valid ? S_TX_DATA : S_TX_HS;
      end
      S_RX_DATA: begin
        if (pkt_from_dec_avail) state_nxt = (clean && is_data) ? S_TX_HS : S_IDLE;
        else if (timeout)       state_nxt = S_IDLE;
      end
      S_TX_HS:   if (pkt_sent) state_nxt = S_IDLE;
      S_TX_DATA: if (pkt_sent) state_nxt = S_WAIT_HS;
      S_WAIT_HS: if (pkt_from_dec_avail || timeout) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pkt_to_enc_avail = state == S_TX_HS || state == S_TX_DATA;
    pkt_to_enc       = pkt_to_enc_avail ? pkt_hold : '0;
    ld_pkt  = 1'b0;
    ld_val  = '0;
    deliver = 1'b0;
    done_ev = 1'b0;
    ok_ev   = 1'b0;
    ack_in  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tok_in) begin
          ld_pkt = 1'b1;
          ld_val = data_in_valid ? data_pkt(tx_pid, data_in) : hs_pkt(PID_NAK);
        end
      end
      S_RX_DATA: begin
        if (pkt_from_dec_avail) begin
          if (clean && is_data) begin
            ld_pkt  = 1'b1;
            ld_val  = hs_pkt(sink_ready ? PID_ACK : PID_NAK);
            deliver = sink_ready & seq_ok;
          end else begin
            done_ev = 1'b1;
          end
        end else if (timeout) begin
          done_ev = 1'b1;
        end
      end
      S_TX_HS: begin
        if (pkt_sent) begin
          done_ev = 1'b1;
          ok_ev   = pkt_hold[90:83] == PID_ACK;
        end
      end
      S_WAIT_HS: begin
        if (pkt_from_dec_avail) begin
          done_ev = 1'b1;
          ok_ev   = clean && rx_pid == PID_ACK;
          ack_in  = clean && rx_pid == PID_ACK;
        end else if (timeout) begin
          done_ev = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outgoing packet is frozen at state entry so later data_in changes cannot leak in.
  always_ff @(posedge clk) begin
    if (ld_pkt) pkt_hold <= ld_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_in_ready  <= 1'b0;
      xact_done      <= 1'b0;
      xact_ok        <= 1'b0;
    end else begin
      timer          <= (state == S_RX_DATA || state == S_WAIT_HS) ? timer + 8'd1 : 8'd0;
      data_out_valid <= deliver;
      data_in_ready  <= ack_in;
      xact_done      <= done_ev;
      xact_ok        <= ok_ev;
      if (deliver) data_out <= pkt_from_dec[82:19];
    end
  end

endmodule
